// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (PC, regfile, ALU, control FSM) on one shared instruction/data memory port.
// CPI 3-5 with zero wait states; memready low stalls FETCH/MEMRD/MEMWR with the request held steady.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          EXT_OPS  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] memaddr,
    output logic [31:0] memwdata,
    input  logic [31:0] memrdata,
    output logic        memread,
    output logic        memwrite,
    input  logic        memready,
    output logic [31:0] pc,
    output logic        illegal
);

    typedef enum logic [3:0] {
        START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, IMMEX, IMMWB, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t      state;
    state_t      dispatch;
    logic [31:0] ir, a, b, aluout, data;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] signimm, zeroimm;
    logic [31:0] rd_a, rd_b;
    logic [31:0] r_res, i_res, diff;
    logic        funct_ok, take;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign signimm = {{16{ir[15]}}, ir[15:0]};
    assign zeroimm = {16'h0000, ir[15:0]};

    assign rd_a = (rs == 5'd0) ? 32'h0 : rf[rs];
    assign rd_b = (rt == 5'd0) ? 32'h0 : rf[rt];

    // Opcode dispatch out of DECODE; FETCH here means the opcode is unsupported.
    always_comb begin
        dispatch = FETCH;
        case (op)
            OP_LW, OP_SW:   dispatch = MEMADR;
            OP_RTYPE:       dispatch = EXECUTE;
            OP_BEQ:         dispatch = BRANCH;
            OP_BNE:         dispatch = EXT_OPS ? BRANCH : FETCH;
            OP_ADDI:        dispatch = IMMEX;
            OP_ANDI, OP_ORI: dispatch = EXT_OPS ? IMMEX : FETCH;
            OP_J:           dispatch = JUMP;
            default:        dispatch = FETCH;
        endcase
    end

    always_comb begin
        r_res    = 32'h0;
        funct_ok = 1'b1;
        case (funct)
            6'h20:   r_res = a + b;
            6'h22:   r_res = a - b;
            6'h24:   r_res = a & b;
            6'h25:   r_res = a | b;
            6'h2A:   r_res = {31'h0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        i_res = a + signimm;
        case (op)
            OP_ANDI: i_res = a & zeroimm;
            OP_ORI:  i_res = a | zeroimm;
            default: i_res = a + signimm;
        endcase
    end

    assign diff = a - b;
    assign take = (op == OP_BNE) ? (diff != 32'h0) : (diff == 32'h0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= START;
            pc     <= RESET_PC;
            ir     <= 32'h0;
            a      <= 32'h0;
            b      <= 32'h0;
            aluout <= 32'h0;
            data   <= 32'h0;
        end else begin
            case (state)
                START:  state <= FETCH;
                FETCH: begin
                    if (memready) begin
                        ir    <= memrdata;
                        pc    <= pc + 32'd4;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a      <= rd_a;
                    b      <= rd_b;
                    aluout <= pc + {signimm[29:0], 2'b00};
                    state  <= dispatch;
                end
                MEMADR: begin
                    aluout <= a + signimm;
                    state  <= (op == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    if (memready) begin
                        data  <= memrdata;
                        state <= MEMWB;
                    end
                end
                MEMWR:   if (memready) state <= FETCH;
                EXECUTE: begin
                    if (funct_ok) begin
                        aluout <= r_res;
                        state  <= ALUWB;
                    end else begin
                        state <= FETCH;
                    end
                end
                IMMEX: begin
                    aluout <= i_res;
                    state  <= IMMWB;
                end
                BRANCH: begin
                    if (take) pc <= aluout;
                    state <= FETCH;
                end
                JUMP: begin
                    pc    <= {pc[31:28], ir[25:0], 2'b00};
                    state <= FETCH;
                end
                MEMWB, ALUWB, IMMWB: state <= FETCH;
                default: state <= START;
            endcase
        end
    end

    // Writeback only happens in WB states, so reset (which forces START) blocks it.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = aluout;
        case (state)
            MEMWB: begin rf_we = 1'b1; rf_wa = rt; rf_wd = data;   end
            ALUWB: begin rf_we = 1'b1; rf_wa = rd; rf_wd = aluout; end
            IMMWB: begin rf_we = 1'b1; rf_wa = rt; rf_wd = aluout; end
            default: rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rf_we && (rf_wa != 5'd0)) rf[rf_wa] <= rf_wd;
    end

    assign memread  = (state == FETCH) || (state == MEMRD);
    assign memwrite = (state == MEMWR);
    assign memaddr  = ((state == MEMRD) || (state == MEMWR)) ? aluout : pc;
    assign memwdata = b;
    assign illegal  = ((state == DECODE) && (dispatch == FETCH)) ||
                      ((state == EXECUTE) && !funct_ok);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench: shared memory model, wait-state control, branch/jump/illegal and mid-request reset.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        memready;
    logic [31:0] memaddr, memwdata, memrdata, pc;
    logic        memread, memwrite, illegal;

    logic [31:0] memaddr2, memwdata2, pc2;
    logic        memread2, memwrite2, illegal2;

    logic [31:0] mem [256];
    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign memrdata = (memaddr < 32'h400) ? mem[memaddr[9:2]] : 32'h0;

    mips_multicycle_core #(.RESET_PC(32'h0), .EXT_OPS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .memaddr(memaddr), .memwdata(memwdata), .memrdata(memrdata),
        .memread(memread), .memwrite(memwrite), .memready(memready),
        .pc(pc), .illegal(illegal)
    );

    // Reduced-ISA core fed a constant ori instruction.
    mips_multicycle_core #(.RESET_PC(32'h0), .EXT_OPS(1'b0)) dut2 (
        .clk(clk), .reset(reset),
        .memaddr(memaddr2), .memwdata(memwdata2), .memrdata(32'h344500F0),
        .memread(memread2), .memwrite(memwrite2), .memready(1'b1),
        .pc(pc2), .illegal(illegal2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; a store handshake seen just before an edge lands in mem on that edge.
    task automatic tick(input int n);
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        for (int i = 0; i < n; i++) begin
            #3;
            we = reset && memwrite && memready;
            wa = memaddr[9:2];
            wd = memwdata;
            @(posedge clk);
            #1;
            if (we) mem[wa] = wd;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h20020005;  // addi $2,$0,5
        mem[1]  = 32'h00421820;  // add  $3,$2,$2
        mem[2]  = 32'hAC030080;  // sw   $3,0x80($0)
        mem[3]  = 32'h8C040080;  // lw   $4,0x80($0)
        mem[4]  = 32'h1042FFFF;  // beq  $2,$2,-1
        mem[5]  = 32'h08000040;  // j    0x40
        mem[64] = 32'hFC000000;  // opcode 0x3F
        mem[65] = 32'h344500F0;  // ori  $5,$2,0xF0
        mem[66] = 32'h00023822;  // sub  $7,$0,$2
        mem[67] = 32'h00E2402A;  // slt  $8,$7,$2
        mem[68] = 32'h30E98033;  // andi $9,$7,0x8033
        mem[69] = 32'h0000183F;  // R-type, funct 0x3F, rd=$3
        mem[70] = 32'hAC080084;  // sw   $8,0x84($0)

        reset    = 1'b0;
        memready = 1'b0;
        #6;
        check("rst_pc", pc, 32'h0);
        check("rst_memaddr", memaddr, 32'h0);
        check("rst_memread", {31'h0, memread}, 32'h0);
        check("rst_memwrite", {31'h0, memwrite}, 32'h0);
        check("rst_illegal", {31'h0, illegal}, 32'h0);
        check("rst_memwdata", memwdata, 32'h0);
        check("rst2_memwdata", memwdata2, 32'h0);
        tick(1);
        reset    = 1'b1;
        memready = 1'b1;

        // addi: START, then FETCH at cycle 1
        tick(1);
        check("fetch0_memread", {31'h0, memread}, 32'h1);
        check("fetch0_memaddr", memaddr, 32'h0);
        check("ext0_fetch_memread", {31'h0, memread2}, 32'h1);
        check("ext0_fetch_memaddr", memaddr2, 32'h0);
        tick(1);
        check("ext0_ori_illegal", {31'h0, illegal2}, 32'h1);
        check("ext0_pc", pc2, 32'h4);
        check("ext0_memwrite", {31'h0, memwrite2}, 32'h0);
        check("addi_decode_illegal", {31'h0, illegal}, 32'h0);
        check("decode_memread", {31'h0, memread}, 32'h0);
        tick(3);
        check("addi_rf2", dut.rf[2], 32'd5);
        check("addi_pc", pc, 32'h4);
        check("addi_next_fetch", {31'h0, memread}, 32'h1);

        // add $3,$2,$2
        tick(4);
        check("add_rf3", dut.rf[3], 32'd10);
        check("add_pc", pc, 32'h8);

        // sw with 3 wait states in MEMWR
        tick(3);
        memready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            check("sw_wait_memwrite", {31'h0, memwrite}, 32'h1);
            check("sw_wait_memread", {31'h0, memread}, 32'h0);
            check("sw_wait_memaddr", memaddr, 32'h80);
            check("sw_wait_memwdata", memwdata, 32'd10);
            check("sw_wait_pc", pc, 32'hC);
            check("sw_wait_mem", mem[32], 32'h0);
            tick(1);
        end
        memready = 1'b1;
        check("sw_hs_memwrite", {31'h0, memwrite}, 32'h1);
        tick(1);
        check("sw_mem80", mem[32], 32'd10);
        check("sw_done_memwrite", {31'h0, memwrite}, 32'h0);
        check("sw_done_memaddr", memaddr, 32'hC);

        // lw with 2 wait states in FETCH and 2 in MEMRD: 9 cycles total
        memready = 1'b0;
        tick(2);
        check("lw_fwait_memread", {31'h0, memread}, 32'h1);
        check("lw_fwait_pc", pc, 32'hC);
        memready = 1'b1;
        tick(3);
        memready = 1'b0;
        check("lw_memrd_memread", {31'h0, memread}, 32'h1);
        check("lw_memrd_memaddr", memaddr, 32'h80);
        tick(2);
        check("lw_rwait_memaddr", memaddr, 32'h80);
        memready = 1'b1;
        tick(1);
        check("lw_memwb_memread", {31'h0, memread}, 32'h0);
        tick(1);
        check("lw_rf4", dut.rf[4], 32'd10);
        check("lw_fetch_memread", {31'h0, memread}, 32'h1);
        check("lw_pc", pc, 32'h10);

        // beq $2,$2,-1 loops back onto itself; then patch it to bne
        tick(3);
        check("beq_pc", pc, 32'h10);
        check("beq_memaddr", memaddr, 32'h10);
        mem[4] = 32'h1442FFFF;
        tick(3);
        check("bne_pc", pc, 32'h14);

        // j 0x40
        tick(3);
        check("j_pc", pc, 32'h100);

        // illegal opcode 0x3F
        tick(1);
        check("bad_op_illegal", {31'h0, illegal}, 32'h1);
        check("bad_op_pc", pc, 32'h104);
        tick(1);
        check("bad_op_pulse_end", {31'h0, illegal}, 32'h0);
        check("bad_op_fetch_addr", memaddr, 32'h104);
        check("bad_op_rf2", dut.rf[2], 32'd5);

        tick(4);
        check("ori_rf5", dut.rf[5], 32'h000000F5);
        tick(4);
        check("sub_rf7", dut.rf[7], 32'hFFFFFFFB);
        tick(4);
        check("slt_rf8", dut.rf[8], 32'h1);
        tick(4);
        check("andi_rf9", dut.rf[9], 32'h00008033);
        check("andi_pc", pc, 32'h114);

        // unsupported funct: pulse in EXECUTE, no writeback
        tick(2);
        check("bad_funct_illegal", {31'h0, illegal}, 32'h1);
        tick(1);
        check("bad_funct_pulse_end", {31'h0, illegal}, 32'h0);
        check("bad_funct_pc", pc, 32'h118);
        check("bad_funct_rf3", dut.rf[3], 32'd10);

        // reset asserted while a store is waiting in MEMWR
        tick(3);
        memready = 1'b0;
        check("rst_sw_memwrite", {31'h0, memwrite}, 32'h1);
        check("rst_sw_memaddr", memaddr, 32'h84);
        #2;
        reset = 1'b0;
        #1;
        check("async_memwrite", {31'h0, memwrite}, 32'h0);
        check("async_pc", pc, 32'h0);
        check("async_memaddr", memaddr, 32'h0);
        tick(1);
        check("async_mem84", mem[33], 32'h0);
        reset    = 1'b1;
        memready = 1'b1;
        check("start_memread", {31'h0, memread}, 32'h0);
        tick(1);
        check("restart_memread", {31'h0, memread}, 32'h1);
        check("restart_memaddr", memaddr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
